// File: rtl/mb_audio_resampler.sv
// mb_audio_resampler: converts the two Mockingboard PSG mix outputs into
// signed 16-bit PCM stereo samples at SAMPLE_HZ, delivered through a small
// valid/ready FIFO.
// Build option: define MB_RESAMPLE_LPF_EN to enable the first-order low-pass
// filter; without it each channel simply holds the last conditioned input.
module mb_audio_resampler #(
    parameter int unsigned CLK_HZ       = 54_000_000,
    parameter int unsigned SAMPLE_HZ    = 48_000,
    parameter int unsigned FILTER_SHIFT = 4,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic               clk_logic,
    input  logic               system_reset_n,
    input  logic               ce_i,
    input  logic               enable_i,
    input  logic [9:0]         audio_l_i,
    input  logic [9:0]         audio_r_i,
    output logic               sample_valid_o,
    input  logic               sample_ready_i,
    output logic signed [15:0] sample_l_o,
    output logic signed [15:0] sample_r_o,
    output logic               overflow_o
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    // Elaboration-time parameter sanity checks.
    if (SAMPLE_HZ >= CLK_HZ) begin : g_bad_rate
        $error("SAMPLE_HZ must be below CLK_HZ");
    end
    if (FILTER_SHIFT < 1 || FILTER_SHIFT > 8) begin : g_bad_shift
        $error("FILTER_SHIFT must be in 1..8");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two, at least 2");
    end

    logic signed [10:0] x_l, x_r;
    logic signed [10:0] y_l, y_r;

    // Remove the DC midpoint; a disabled block feeds silence into the filter.
    always_comb begin
        x_l = '0;
        x_r = '0;
        if (enable_i) begin
            x_l = $signed({1'b0, audio_l_i}) - 11'sd384;
            x_r = $signed({1'b0, audio_r_i}) - 11'sd384;
        end
    end

`ifdef MB_RESAMPLE_LPF_EN
    localparam int unsigned AW = 11 + FILTER_SHIFT;

    logic signed [AW-1:0] acc_l, acc_r;
    logic signed [AW-1:0] xe_l, xe_r;
    logic signed [AW-1:0] dec_l, dec_r;

    assign xe_l  = {{FILTER_SHIFT{x_l[10]}}, x_l};
    assign xe_r  = {{FILTER_SHIFT{x_r[10]}}, x_r};
    // acc >>> S written as an explicit sign-extended slice
    assign dec_l = {{FILTER_SHIFT{acc_l[AW-1]}}, acc_l[AW-1:FILTER_SHIFT]};
    assign dec_r = {{FILTER_SHIFT{acc_r[AW-1]}}, acc_r[AW-1:FILTER_SHIFT]};
    assign y_l   = acc_l[AW-1:FILTER_SHIFT];
    assign y_r   = acc_r[AW-1:FILTER_SHIFT];

    // Leaky integrator advanced once per PSG update strobe.
    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            acc_l <= '0;
            acc_r <= '0;
        end else if (ce_i) begin
            acc_l <= acc_l + xe_l - dec_l;
            acc_r <= acc_r + xe_r - dec_r;
        end
    end
`else
    logic signed [10:0] hold_l, hold_r;

    assign y_l = hold_l;
    assign y_r = hold_r;

    // Unfiltered: capture the conditioned input on each PSG update strobe.
    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            hold_l <= '0;
            hold_r <= '0;
        end else if (ce_i) begin
            hold_l <= x_l;
            hold_r <= x_r;
        end
    end
`endif

    logic [31:0] phase;
    logic [32:0] phase_sum;
    logic        tick;

    assign phase_sum = {1'b0, phase} + 33'(SAMPLE_HZ);
    assign tick      = (phase_sum >= 33'(CLK_HZ));

    // Fractional phase accumulator: SAMPLE_HZ ticks per CLK_HZ cycles, no drift.
    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            phase <= '0;
        end else if (tick) begin
            phase <= 32'(phase_sum - 33'(CLK_HZ));
        end else begin
            phase <= phase_sum[31:0];
        end
    end

    logic [31:0] mem [FIFO_DEPTH];
    logic [PW:0] wr_ptr, rd_ptr;
    logic        empty, full, pop, push;
    logic [31:0] head;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign pop   = !empty && sample_ready_i;
    assign push  = tick && (!full || pop);
    assign head  = mem[rd_ptr[PW-1:0]];

    assign sample_valid_o = !empty;
    assign sample_l_o     = head[31:16];
    assign sample_r_o     = head[15:0];

    // Sample FIFO; a tick into a full FIFO without a pop is dropped and flagged.
    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_o <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr[PW-1:0]] <= {y_l, 5'b0, y_r, 5'b0};
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (tick && full && !pop) begin
                overflow_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mb_audio_resampler.sv
// tb_mb_audio_resampler: directed stimulus with a behavioural reference model
// (integer filter arithmetic, queue-based FIFO) checked every cycle, plus
// hand-computed literal expectations.
module tb_mb_audio_resampler;

    localparam int CH    = 100;
    localparam int SH    = 3;
    localparam int S     = 4;
    localparam int DEPTH = 4;

    logic              clk;
    logic              rst_n;
    logic              ce;
    logic              enable;
    logic [9:0]        audio_l;
    logic [9:0]        audio_r;
    logic              ready;
    logic              dut_valid;
    logic signed [15:0] dut_l;
    logic signed [15:0] dut_r;
    logic              dut_ovf;

    int total = 0;
    int bad   = 0;

    mb_audio_resampler #(
        .CLK_HZ      (CH),
        .SAMPLE_HZ   (SH),
        .FILTER_SHIFT(S),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk_logic     (clk),
        .system_reset_n(rst_n),
        .ce_i          (ce),
        .enable_i      (enable),
        .audio_l_i     (audio_l),
        .audio_r_i     (audio_r),
        .sample_valid_o(dut_valid),
        .sample_ready_i(ready),
        .sample_l_o    (dut_l),
        .sample_r_o    (dut_r),
        .overflow_o    (dut_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int     m_acc_l, m_acc_r;
    longint m_phase;
    int     q_l[$];
    int     q_r[$];
    bit     m_ovf;

    function automatic int floor_div(input int a, input int d);
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    function automatic int cond_x(input bit en, input int a);
        return en ? (a - 384) : 0;
    endfunction

    function automatic int model_y(input int acc);
`ifdef MB_RESAMPLE_LPF_EN
        return floor_div(acc, 1 << S);
`else
        return acc;
`endif
    endfunction

    function automatic int model_next(input int acc, input int x);
`ifdef MB_RESAMPLE_LPF_EN
        return acc + x - floor_div(acc, 1 << S);
`else
        return x;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit tk;
        bit pp;
        if (!rst_n) begin
            m_acc_l = 0;
            m_acc_r = 0;
            m_phase = 0;
            q_l.delete();
            q_r.delete();
            m_ovf = 1'b0;
        end else begin
            tk = 1'b0;
            m_phase = m_phase + SH;
            if (m_phase >= CH) begin
                m_phase = m_phase - CH;
                tk = 1'b1;
            end
            pp = (q_l.size() != 0) && ready;
            if (pp) begin
                void'(q_l.pop_front());
                void'(q_r.pop_front());
            end
            if (tk) begin
                if (q_l.size() < DEPTH) begin
                    q_l.push_back(model_y(m_acc_l) * 32);
                    q_r.push_back(model_y(m_acc_r) * 32);
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (ce) begin
                m_acc_l = model_next(m_acc_l, cond_x(enable, int'(audio_l)));
                m_acc_r = model_next(m_acc_r, cond_x(enable, int'(audio_r)));
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("valid", int'(dut_valid), int'(q_l.size() != 0));
            check("overflow", int'(dut_ovf), int'(m_ovf));
            if (q_l.size() != 0) begin
                check("head_l", int'(dut_l), q_l[0]);
                check("head_r", int'(dut_r), q_r[0]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at a negedge; returns at the negedge just before a ticking edge.
    task automatic wait_tick();
        for (int i = 0; i < 200; i++) begin
            if (m_phase + SH >= CH) return;
            @(negedge clk);
        end
        total++;
        bad++;
        $display("FAIL tick_wait: got no tick expected tick within 200 cycles");
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 200; i++) begin
            if (dut_valid) return;
            @(negedge clk);
        end
        total++;
        bad++;
        $display("FAIL valid_wait: got valid=0 expected valid=1 within 200 cycles");
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_c;
        int cnt;
        int prev_c;
        int spacing_bad;
        int pops;
        int exp_l1;
        int exp_r1;

        rst_n   = 1'b1;
        ce      = 1'b1;
        enable  = 1'b1;
        audio_l = 10'd765;
        audio_r = 10'd123;
        ready   = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_valid", int'(dut_valid), 0);
        check("rst_l", int'(dut_l), 0);
        check("rst_r", int'(dut_r), 0);
        check("rst_ovf", int'(dut_ovf), 0);
        cycles(3);
        check("rst_hold_valid", int'(dut_valid), 0);
        check("rst_hold_ovf", int'(dut_ovf), 0);

        // Release; measure tick rate with ready=1 and no PSG activity.
        ce      = 1'b0;
        audio_l = 10'd765;
        audio_r = 10'd0;
        rst_n   = 1'b1;
        first_c = -1;
        cnt = 0;
        prev_c = 0;
        spacing_bad = 0;
        for (int c = 1; c <= 1010; c++) begin
            @(negedge clk);
            if (dut_valid) begin
                cnt++;
                if (first_c < 0) begin
                    first_c = c;
                    check("first_head_l", int'(dut_l), 0);
                    check("first_head_r", int'(dut_r), 0);
                end else if ((c - prev_c) != 33 && (c - prev_c) != 34) begin
                    spacing_bad++;
                end
                prev_c = c;
            end
        end
        check("first_valid_cycle", first_c, 34);
        check("tick_count", cnt, 30);
        check("tick_spacing_bad", spacing_bad, 0);

        // One PSG update with full-scale left, zero right; next sample shows it.
        ready = 1'b0;
        ce    = 1'b1;
        @(negedge clk);
        ce = 1'b0;
        wait_valid();
`ifdef MB_RESAMPLE_LPF_EN
        exp_l1 = 736;
        exp_r1 = -768;
`else
        exp_l1 = 12192;
        exp_r1 = -12288;
`endif
        check("one_ce_l", int'(dut_l), exp_l1);
        check("one_ce_r", int'(dut_r), exp_r1);

        // DC settle: ce every cycle for 500 cycles.
        ready = 1'b1;
        ce    = 1'b1;
        cycles(500);
        ce = 1'b0;
        cycles(2);
        ready = 1'b0;
        wait_valid();
        check("settle_l", int'(dut_l), 12192);
        check("settle_r", int'(dut_r), -12288);

        // Backpressure: fill with four distinct samples.
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            audio_l = 10'(k * 200);
            audio_r = 10'(765 - k * 200);
            ce = 1'b1;
            @(negedge clk);
            ce = 1'b0;
            wait_tick();
            @(negedge clk);
        end
        check("full_valid", int'(dut_valid), 1);
        check("full_ovf", int'(dut_ovf), 0);

        // Tick while full with a simultaneous pop: push accepted.
        wait_tick();
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check("full_pushpop_ovf", int'(dut_ovf), 0);
        check("full_pushpop_valid", int'(dut_valid), 1);

        // Tick while full without a pop: dropped, sticky overflow.
        wait_tick();
        @(negedge clk);
        check("drop_ovf", int'(dut_ovf), 1);

        // Drain in order.
        ready = 1'b1;
        pops  = 0;
        for (int i = 0; i < 10; i++) begin
            if (!dut_valid) break;
            pops++;
            @(negedge clk);
        end
        check("drain_pops", pops, 4);
        check("drain_valid", int'(dut_valid), 0);
        check("drain_ovf_sticky", int'(dut_ovf), 1);

        // Disabled input: decay toward silence.
        enable  = 1'b0;
        audio_l = 10'd765;
        audio_r = 10'd765;
        ce      = 1'b1;
        cycles(300);
        ce = 1'b0;
        cycles(2);
        ready = 1'b0;
        wait_valid();
        check("silence_l", int'(dut_l), 0);
        check("silence_r", int'(dut_r), 0);

        // Build up a non-zero queued sample, then reset asynchronously.
        enable = 1'b1;
        ready  = 1'b1;
        ce     = 1'b1;
        cycles(40);
        ce    = 1'b0;
        ready = 1'b0;
        cycles(1);
        wait_valid();
        check("pre_reset_valid", int'(dut_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", int'(dut_valid), 0);
        check("async_rst_l", int'(dut_l), 0);
        check("async_rst_r", int'(dut_r), 0);
        check("async_rst_ovf", int'(dut_ovf), 0);
        cycles(2);
        rst_n = 1'b1;
        ready = 1'b1;
        cycles(60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
